delay_timer_mc: RTL and testbench



---
 rtl/delay_timer_mc.sv | 149 ++++++++++++++
 tb/tb_delay_timer_mc.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/delay_timer_mc.sv
// delay_timer_mc: NUM_CH independent one-shot / delayed-operate / delayed-release / dual-delay timers.
// Optional macro DELAY_TIMER_RETRIG_EN makes one-shot pulses retriggerable.
module delay_timer_mc #(
  parameter int NUM_CH           = 4,
  parameter int WEIGHT_BIT_WIDTH = 8,
  parameter int TICK_DIV         = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CH-1:0]                  trigger_in,
  input  logic [NUM_CH-1:0]                  mode_a,
  input  logic [NUM_CH-1:0]                  mode_b,
  input  logic [NUM_CH*WEIGHT_BIT_WIDTH-1:0] weighted_bits,
  output logic [NUM_CH-1:0]                  delay_out_n,
  output logic [NUM_CH-1:0]                  busy
);

  localparam int CW = WEIGHT_BIT_WIDTH + $clog2(TICK_DIV);
  localparam logic [CW-1:0] TDIV = CW'(TICK_DIV);

  typedef enum logic [1:0] {IDLE, OP_WAIT, ACTIVE, REL_WAIT} state_t;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [1:0]                  mode_q, mode_d;
    logic [WEIGHT_BIT_WIDTH-1:0] w_q, w_d;
    logic                        trig_q;
    logic                        out_n_q, out_n_d;
    logic                        busy_q, busy_d;
    logic [WEIGHT_BIT_WIDTH-1:0] w_in;
    logic [1:0]                  mode_in;
    logic                        trig, rise, term;
    logic [CW-1:0]               last_cnt;

    assign w_in     = weighted_bits[c*WEIGHT_BIT_WIDTH +: WEIGHT_BIT_WIDTH];
    assign mode_in  = {mode_b[c], mode_a[c]};
    assign trig     = trigger_in[c];
    assign rise     = trig & ~trig_q;
    // Latched weight is never zero outside IDLE, so D-1 cannot underflow.
    assign last_cnt = CW'(w_q) * TDIV - CW'(1);
    assign term     = (cnt_q == last_cnt);

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      w_d     = w_q;
      unique case (state_q)
        IDLE: begin
          cnt_d  = '0;
          mode_d = mode_in;
          w_d    = w_in;
          if (w_in != '0) begin
            case (mode_in)
              2'b00:   if (rise) state_d = ACTIVE;
              2'b01:   if (trig) state_d = ACTIVE;
              default: if (trig) state_d = OP_WAIT;
            endcase
          end
        end
        OP_WAIT: begin
          if (term) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else if (!trig) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ACTIVE: begin
          case (mode_q)
            2'b00: begin
`ifdef DELAY_TIMER_RETRIG_EN
              if (rise) begin
                cnt_d = '0;
              end else if (term) begin
                state_d = IDLE;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
`else
              if (term) begin
                state_d = IDLE;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
`endif
            end
            2'b10: if (!trig) state_d = IDLE;
            default: begin
              if (!trig) begin
                state_d = REL_WAIT;
                cnt_d   = '0;
              end
            end
          endcase
        end
        REL_WAIT: begin
          // Retrigger takes priority over the terminal count.
          if (trig) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else if (term) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign out_n_d = !((state_d == ACTIVE) || (state_d == REL_WAIT));
    assign busy_d  = (state_d != IDLE);

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        mode_q  <= 2'b00;
        w_q     <= '0;
        trig_q  <= 1'b1;
        out_n_q <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        mode_q  <= mode_d;
        w_q     <= w_d;
        trig_q  <= trig;
        out_n_q <= out_n_d;
        busy_q  <= busy_d;
      end
    end

    assign delay_out_n[c] = out_n_q;
    assign busy[c]        = busy_q;
  end

endmodule

// File: tb/tb_delay_timer_mc.sv
// Directed bench for delay_timer_mc: a multi-channel vector table plus per-mode timing sequences.
module tb_delay_timer_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  trig, ma, mb;
  logic [31:0] w;
  logic [3:0]  out_n, bsy, out4_n, bsy4;

  int errors = 0;
  int checks = 0;

  delay_timer_mc #(.NUM_CH(4), .WEIGHT_BIT_WIDTH(8), .TICK_DIV(1)) dut (
    .clk(clk), .rst(rst), .trigger_in(trig), .mode_a(ma), .mode_b(mb),
    .weighted_bits(w), .delay_out_n(out_n), .busy(bsy)
  );

  delay_timer_mc #(.NUM_CH(4), .WEIGHT_BIT_WIDTH(8), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .trigger_in(trig), .mode_a(ma), .mode_b(mb),
    .weighted_bits(w), .delay_out_n(out4_n), .busy(bsy4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  trig;
    logic [3:0]  ma;
    logic [3:0]  mb;
    logic [31:0] w;
    logic [3:0]  eo;
    logic [3:0]  eb;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] t, input logic [3:0] a, input logic [3:0] b,
                     input logic [31:0] wv, input logic [3:0] eo, input logic [3:0] eb);
    vec_t v;
    v.trig = t; v.ma = a; v.mb = b; v.w = wv; v.eo = eo; v.eb = eb;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    trig = 4'b0000;
    tick();
    rst  = 1'b0;
  endtask

  task automatic set_ch0(input logic [1:0] mode, input logic [7:0] wt);
    ma = {3'b000, mode[0]};
    mb = {3'b000, mode[1]};
    w  = {24'h0, wt};
  endtask

  localparam logic [3:0]  MA = 4'b1010;
  localparam logic [3:0]  MB = 4'b1100;
  localparam logic [31:0] WB = 32'h0002_0203;

  initial begin
    logic exp_o, exp_b;
    rst = 1'b1; trig = '0; ma = '0; mb = '0; w = '0;

    // ch0 one-shot W=3, ch1 release W=2, ch2 operate W=2, ch3 dual W=0 (disabled)
    add(4'b0000, MA, MB,      WB,           4'b1111, 4'b0000);
    add(4'b1111, MA, MB,      WB,           4'b1100, 4'b0111);
    add(4'b1111, MA, 4'b1101, 32'h00020208, 4'b1100, 4'b0111);
    add(4'b1111, MA, 4'b1101, 32'h00020208, 4'b1000, 4'b0111);
    add(4'b1001, MA, MB,      WB,           4'b1101, 4'b0010);
    add(4'b1001, MA, MB,      WB,           4'b1101, 4'b0010);
    add(4'b1001, MA, MB,      WB,           4'b1111, 4'b0000);
    add(4'b0000, MA, MB,      WB,           4'b1111, 4'b0000);
    add(4'b0011, MA, MB,      WB,           4'b1100, 4'b0011);
    add(4'b0001, MA, MB,      WB,           4'b1100, 4'b0011);
    add(4'b0010, MA, MB,      WB,           4'b1100, 4'b0011);
    add(4'b0010, MA, MB,      WB,           4'b1101, 4'b0010);
    add(4'b0000, MA, MB,      WB,           4'b1101, 4'b0010);
    add(4'b0000, MA, MB,      WB,           4'b1101, 4'b0010);
    add(4'b0000, MA, MB,      WB,           4'b1111, 4'b0000);

    tick();
    chk("reset_out_n", out_n, 4'b1111);
    chk("reset_busy", bsy, 4'b0000);
    chk("reset_out_n_div4", out4_n, 4'b1111);
    chk("reset_busy_div4", bsy4, 4'b0000);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      trig = tbl[i].trig; ma = tbl[i].ma; mb = tbl[i].mb; w = tbl[i].w;
      tick();
      chk($sformatf("tbl%0d_out_n", i), out_n, tbl[i].eo);
      chk($sformatf("tbl%0d_busy", i), bsy, tbl[i].eb);
    end

    // One-shot W=10, second rising edge at k+5
    do_reset();
    set_ch0(2'b00, 8'd10);
    tick();
    for (int m = 0; m < 20; m++) begin
      trig = {3'b000, (m == 0) || (m == 5)};
      tick();
`ifdef DELAY_TIMER_RETRIG_EN
      exp_o = (m >= 15);
`else
      exp_o = (m >= 10);
`endif
      chk($sformatf("oneshot_m%0d", m), {3'b000, out_n[0]}, {3'b000, exp_o});
    end

    // Delayed operate W=10, held 15 cycles
    do_reset();
    set_ch0(2'b10, 8'd10);
    for (int m = 0; m < 18; m++) begin
      trig = {3'b000, m < 15};
      tick();
      exp_o = !(m >= 10 && m < 15);
      exp_b = (m < 15);
      chk($sformatf("op_out_m%0d", m), {3'b000, out_n[0]}, {3'b000, exp_o});
      chk($sformatf("op_busy_m%0d", m), {3'b000, bsy[0]}, {3'b000, exp_b});
    end

    // Delayed operate W=10, held only 2 cycles
    do_reset();
    set_ch0(2'b10, 8'd10);
    for (int m = 0; m < 5; m++) begin
      trig = {3'b000, m < 2};
      tick();
      chk($sformatf("opshort_out_m%0d", m), {3'b000, out_n[0]}, 4'b0001);
      chk($sformatf("opshort_busy_m%0d", m), {3'b000, bsy[0]}, {3'b000, m < 2});
    end

    // Delayed release W=10: high 30 cycles, then low
    do_reset();
    set_ch0(2'b01, 8'd10);
    for (int m = 0; m < 43; m++) begin
      trig = {3'b000, m < 30};
      tick();
      chk($sformatf("rel_out_m%0d", m), {3'b000, out_n[0]}, {3'b000, m >= 40});
      chk($sformatf("rel_busy_m%0d", m), {3'b000, bsy[0]}, {3'b000, m < 40});
    end

    // Delayed release W=10 with a 2-cycle low glitch
    do_reset();
    set_ch0(2'b01, 8'd10);
    for (int m = 0; m < 29; m++) begin
      trig = {3'b000, (m < 5) || (m >= 7 && m < 16)};
      tick();
      chk($sformatf("glitch_out_m%0d", m), {3'b000, out_n[0]}, {3'b000, m >= 26});
    end

    // Dual W=10, TICK_DIV=4 (D=40): high 60 cycles, then low
    do_reset();
    set_ch0(2'b11, 8'd10);
    for (int m = 0; m < 103; m++) begin
      trig = {3'b000, m < 60};
      tick();
      exp_o = !(m >= 40 && m < 100);
      chk($sformatf("dual4_out_m%0d", m), {3'b000, out4_n[0]}, {3'b000, exp_o});
      chk($sformatf("dual4_busy_m%0d", m), {3'b000, bsy4[0]}, {3'b000, m < 100});
    end

    // Reset in OP_WAIT, ACTIVE and REL_WAIT (dual W=3)
    for (int s = 0; s < 3; s++) begin
      do_reset();
      set_ch0(2'b11, 8'd3);
      trig = 4'b0001;
      tick();
      if (s >= 1) begin
        repeat (3) tick();
      end
      if (s == 2) begin
        trig = 4'b0000;
        tick();
      end
      chk($sformatf("pre_rst%0d_out_n", s), out_n, (s == 0) ? 4'b1111 : 4'b1110);
      chk($sformatf("pre_rst%0d_busy", s), bsy, 4'b0001);
      rst = 1'b1;
      tick();
      chk($sformatf("rst%0d_out_n", s), out_n, 4'b1111);
      chk($sformatf("rst%0d_busy", s), bsy, 4'b0000);
      rst = 1'b0;
    end

    // One-shot with trigger held high across reset must not fire
    set_ch0(2'b00, 8'd3);
    trig = 4'b0001;
    rst  = 1'b1;
    tick();
    rst  = 1'b0;
    for (int m = 0; m < 4; m++) begin
      tick();
      chk($sformatf("held_out_m%0d", m), out_n, 4'b1111);
      chk($sformatf("held_busy_m%0d", m), bsy, 4'b0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
